// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// Holds the FSM state encoding, the default operand width and the counter-width helper.
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/response bundle between the ALU control and the multiplier.
// The master drives the operands and start; the slave returns busy, done and product.
interface seq_multiplier_if import seq_multiplier_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (output start, output a, output b,
                    input  busy,  input  done, input product);
    modport slave  (input  start, input  a, input  b,
                    output busy,  output done, output product);
endinterface

// File: rtl/seq_multiplier_rca.sv
// WIDTH-bit ripple-carry adder built from full_adder cells.
// Purely combinational; the multiplier reuses one instance every iteration.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_carry_adder import seq_multiplier_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry_s;

    assign carry_s[0] = cin;
    assign cout       = carry_s[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry_s[i]),
            .sum  (sum[i]),
            .cout (carry_s[i+1])
        );
    end
endmodule

// File: rtl/seq_multiplier.sv
// Multicycle unsigned shift-and-add multiplier: one ripple add per cycle,
// WIDTH iterations per operation, exact 2*WIDTH-bit product with a one-cycle done pulse.
module seq_multiplier import seq_multiplier_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    seq_multiplier_if.slave   bus
);
    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e               state_q,   state_d;
    logic [WIDTH-1:0]     m_q,       m_d;
    logic [2*WIDTH:0]     p_q,       p_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    logic [WIDTH-1:0]     sum_s;
    logic                 cout_s;

    ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (p_q[2*WIDTH-1:WIDTH]),
        .b    (m_q),
        .cin  (1'b0),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Next-state, datapath and output computation
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    m_d     = bus.a;
                    p_d     = {{(WIDTH+1){1'b0}}, bus.b};
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                // Carry-out lands in the top half so the product is never truncated
                if (p_q[0]) begin
                    p_d = {1'b0, cout_s, sum_s, p_q[WIDTH-1:1]};
                end else begin
                    p_d = {2'b00, p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    product_d = p_d[2*WIDTH-1:0];
                end else begin
                    state_d   = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier with a product scoreboard.
module tb_seq_multiplier;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    logic [2*W-1:0] sb_q[$];

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit later, and score any done pulse.
    task automatic tick();
        logic [2*W-1:0] exp;
        @(posedge clk);
        #1;
        if (bus.done === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("spurious_done", 64'(bus.done), 64'd0);
            end else begin
                exp = sb_q.pop_front();
                check("product", bus.product, exp);
            end
        end
    endtask

    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_result);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        if (expect_result) sb_q.push_back(64'(a) * 64'(b));
        tick();
        bus.start = 1'b0;
        check("busy_after_accept", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("latency", 64'(lat), 64'(W));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        drive_start(a, b, 1'b1);
        wait_done(lat);
        tick();
        check("busy_after_done", 64'(bus.busy), 64'd0);
        check("done_pulse_width", 64'(bus.done), 64'd0);
    endtask

    initial begin
        int lat;
        int done_base;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset held for three cycles
        reset = 1'b1;
        repeat (3) tick();
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_product", bus.product, 64'd0);
        reset = 1'b0;
        done_base = n_done;
        repeat (5) tick();
        check("no_done_without_start", 64'(n_done - done_base), 64'd0);

        // Basic multiply and hold of the result
        run_op(32'd3, 32'd5);
        repeat (10) tick();
        check("product_hold", bus.product, 64'd15);

        // Full-scale and boundary operands
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("max_operands", bus.product, 64'hFFFF_FFFE_0000_0001);
        run_op(32'h8000_0000, 32'd2);
        check("msb_shift", bus.product, 64'h0000_0001_0000_0000);
        run_op(32'd0, 32'h1234_5678);
        check("zero_product", bus.product, 64'd0);
        run_op(32'hDEAD_BEEF, 32'h0000_0001);
        run_op(32'h0001_0000, 32'h0001_0000);

        // Starts while busy and in the done cycle are ignored
        done_base = n_done;
        drive_start(32'd7, 32'd6, 1'b1);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            bus.start = (i == 1 || i == 15);
            bus.a     = 32'd9;
            bus.b     = 32'd9;
            tick();
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("latency_ignored_starts", 64'(lat), 64'(W));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_in_done_ignored", 64'(bus.busy), 64'd0);
        repeat (40) tick();
        check("single_done_pulse", 64'(n_done - done_base), 64'd1);
        check("product_after_ignored", bus.product, 64'd42);

        // Reset aborts an operation in flight
        drive_start(32'd11, 32'd13, 1'b0);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_product", bus.product, 64'd0);
        done_base = n_done;
        run_op(32'd7, 32'd6);
        check("after_abort_product", bus.product, 64'd42);
        check("after_abort_one_done", 64'(n_done - done_base), 64'd1);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
